// File: rtl/banner_pkg.sv
// Shared definitions for the rotating banner: character codes, FSM states,
// the active-low anode table and a window nibble selector.
package banner_pkg;

    localparam logic [3:0] CH_O     = 4'h0;
    localparam logic [3:0] CH_I     = 4'h1;
    localparam logic [3:0] CH_H     = 4'h2;
    localparam logic [3:0] CH_L     = 4'h3;
    localparam logic [3:0] CH_R     = 4'h4;
    localparam logic [3:0] CH_S     = 4'h5;
    localparam logic [3:0] CH_SPACE = 4'h6;
    localparam logic [3:0] CH_B     = 4'hB;
    localparam logic [3:0] CH_E     = 4'hE;
    localparam logic [3:0] CH_F     = 4'hF;

    localparam logic [15:0] WINDOW_BLANK = {4{CH_SPACE}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        HOLD   = 2'd2
    } banner_state_e;

    // Entry n pulls digit n's anode low; entry 0 is the rightmost digit.
    localparam logic [3:0][3:0] ANODE_TABLE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    function automatic logic [3:0] window_nibble(input logic [15:0] w, input logic [1:0] sel);
        return w[{sel, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/banner_prescaler.sv
// Enable-gated modulo-DIV counter; tick is high on the enabled cycle that
// completes each group of DIV enabled cycles. clr forces the count to zero.
module banner_prescaler #(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == TERM);

    always_ff @(posedge clock) begin
        if (!reset_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/banner_scroll_ctrl.sv
// Rotating 4-digit banner sequencer: message buffer, scroll FSM and anode mux.
// Optional post-wrap pause is enabled by defining BANNER_PAUSE_EN.
module banner_scroll_ctrl
    import banner_pkg::*;
#(
    parameter int MAX_LEN     = 32,
    parameter int MUX_DIV     = 100000,
    parameter int SCROLL_DIV  = 250,
    parameter int PAUSE_STEPS = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [$clog2(MAX_LEN)-1:0] wr_addr,
    input  logic [3:0]                 wr_data,
    input  logic [$clog2(MAX_LEN):0]   msg_len,
    input  logic                       start,
    input  logic                       stop,
    output logic                       busy,
    output logic [15:0]                window,
    output logic [1:0]                 digit_sel,
    output logic [3:0]                 anode,
    output logic [3:0]                 digit_code,
    output logic                       scroll_tick,
    output logic                       wrap
);
    localparam int ADDR_W = $clog2(MAX_LEN);
    localparam int LEN_W  = ADDR_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    banner_state_e     state, state_next;
    logic [3:0]        buf_mem [MAX_LEN];
    logic [ADDR_W-1:0] ptr, ptr_next;
    logic [LEN_W-1:0]  len_q, len_next;
    logic [15:0]       window_next;
    logic [1:0]        digit_sel_next;
    logic              refresh_tick, period_tick, period_en, period_clr;
    logic              len_ok, load, shift, last;

    // The address width exactly covers the buffer depth, so every address is
    // in range; the write port is read-first against the shift below.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            buf_mem[wr_addr] <= wr_data;
        end
    end

    banner_prescaler #(.DIV(MUX_DIV)) u_refresh (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (1'b1),
        .clr     (1'b0),
        .tick    (refresh_tick)
    );

    assign period_en = refresh_tick && (state != IDLE);

    banner_prescaler #(.DIV(SCROLL_DIV)) u_scroll (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (period_en),
        .clr     (period_clr),
        .tick    (period_tick)
    );

`ifdef BANNER_PAUSE_EN
    logic hold_done;

    // Counts whole scroll periods spent in HOLD; restarts on every HOLD entry.
    banner_prescaler #(.DIV(PAUSE_STEPS)) u_hold (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (period_tick && (state == HOLD)),
        .clr     (state != HOLD),
        .tick    (hold_done)
    );
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // stop beats start; a start with an out-of-range length is ignored everywhere.
    always_comb begin
        len_ok     = (msg_len != '0) && (msg_len <= MAX_LEN_L);
        load       = start && !stop && len_ok;
        last       = ({1'b0, ptr} == (len_q - LEN_W'(1)));
        state_next = state;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    state_next = SCROLL;
                end
            end
            SCROLL: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (!load && period_tick) begin
                    shift = 1'b1;
`ifdef BANNER_PAUSE_EN
                    if (last) begin
                        state_next = HOLD;
                    end
`endif
                end
            end
`ifdef BANNER_PAUSE_EN
            HOLD: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (load || hold_done) begin
                    state_next = SCROLL;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        window_next    = window;
        ptr_next       = ptr;
        len_next       = len_q;
        if (load) begin
            window_next = WINDOW_BLANK;
            ptr_next    = '0;
            len_next    = msg_len;
        end else if (shift) begin
            window_next = {window[11:0], buf_mem[ptr]};
            ptr_next    = last ? '0 : ptr + 1'b1;
        end
        period_clr     = (state == IDLE) || load || stop;
        digit_sel_next = digit_sel + {1'b0, refresh_tick};
    end

    // anode and digit_code follow the next-state values so they change on the
    // same edge as digit_sel and window.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            window      <= WINDOW_BLANK;
            ptr         <= '0;
            len_q       <= '0;
            digit_sel   <= '0;
            anode       <= ANODE_TABLE[0];
            digit_code  <= CH_SPACE;
            scroll_tick <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            window      <= window_next;
            ptr         <= ptr_next;
            len_q       <= len_next;
            digit_sel   <= digit_sel_next;
            anode       <= ANODE_TABLE[digit_sel_next];
            digit_code  <= window_nibble(window_next, digit_sel_next);
            scroll_tick <= shift;
            wrap        <= shift && last;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_banner_scroll_ctrl.sv
// Directed scoreboard bench for banner_scroll_ctrl; expected windows are queued
// by the stimulus and consumed by a monitor on every scroll_tick.
module tb_banner_scroll_ctrl;
    import banner_pkg::*;

    localparam int MAX_LEN     = 32;
    localparam int MUX_DIV     = 4;
    localparam int SCROLL_DIV  = 2;
    localparam int PAUSE_STEPS = 2;
    localparam int ADDR_W      = 5;
    localparam int LEN_W       = 6;
`ifdef BANNER_PAUSE_EN
    localparam int WRAP_GAP = 24;
`else
    localparam int WRAP_GAP = 8;
`endif

    logic              clock   = 1'b0;
    logic              reset_n = 1'b0;
    logic              wr_en   = 1'b0;
    logic              start   = 1'b0;
    logic              stop    = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [3:0]        wr_data = '0;
    logic [LEN_W-1:0]  msg_len = '0;
    logic              busy, scroll_tick, wrap;
    logic [15:0]       window;
    logic [1:0]        digit_sel;
    logic [3:0]        anode, digit_code;

    logic [16:0] exp_q[$];
    logic [16:0] exp_w;
    int          tick_cyc_q[$];
    int          n_checks   = 0;
    int          n_errors   = 0;
    int          tick_count = 0;
    int          cyc        = 0;
    int          rst_cyc    = 0;
    logic [3:0]  anode_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    banner_scroll_ctrl #(
        .MAX_LEN     (MAX_LEN),
        .MUX_DIV     (MUX_DIV),
        .SCROLL_DIV  (SCROLL_DIV),
        .PAUSE_STEPS (PAUSE_STEPS)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .msg_len     (msg_len),
        .start       (start),
        .stop        (stop),
        .busy        (busy),
        .window      (window),
        .digit_sel   (digit_sel),
        .anode       (anode),
        .digit_code  (digit_code),
        .scroll_tick (scroll_tick),
        .wrap        (wrap)
    );

    // ---- clock / cycle bookkeeping ----
    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc     <= cyc + 1;
        rst_cyc <= reset_n ? rst_cyc + 1 : 0;
    end

    // ---- checking helpers ----
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] exp_nibble(input logic [15:0] w, input int sel);
        logic [15:0] s;
        s = w >> (4 * sel);
        return s[3:0];
    endfunction

    // ---- monitor: every shift must match the head of the expected queue ----
    always @(negedge clock) begin
        if (scroll_tick === 1'b1) begin
            tick_count++;
            tick_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_tick: got window %h wrap %b, expected no shift (cycle %0d)",
                         window, wrap, cyc);
            end else begin
                exp_w = exp_q.pop_front();
                check("scroll_window", {15'b0, wrap, window}, {15'b0, exp_w});
            end
        end
    end

    // ---- driver tasks ----
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic write_char(input int addr, input logic [3:0] data);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = data;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic start_pulse(input int len);
        msg_len = LEN_W'(len);
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic push_exp(input logic wrap_e, input logic [15:0] w);
        exp_q.push_back({wrap_e, w});
    endtask

    task automatic wait_tick_total(input int target, input int budget);
        int t;
        t = 0;
        while (tick_count < target && t < budget) begin
            step();
            t++;
        end
        check("tick_wait", 32'(tick_count), 32'(target));
    endtask

    // ---- stimulus ----
    initial begin
        int base;
        int bad;

        steps(3);
        reset_n = 1'b1;

        // Idle: anode walks the digits with a 4-cycle dwell, window blank.
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_anode", 32'(anode), 32'(anode_exp[(rst_cyc / 4) % 4]));
        end
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_window", 32'(window), 32'h6666);
        check("idle_digit_code", 32'(digit_code), 32'h6);
        check("idle_no_tick", 32'(tick_count), 32'd0);

        // HELLO scroll.
        write_char(0, CH_H);
        write_char(1, CH_E);
        write_char(2, CH_L);
        write_char(3, CH_L);
        write_char(4, CH_O);
        tick_cyc_q.delete();
        base = tick_count;
        push_exp(1'b0, 16'h6662);
        push_exp(1'b0, 16'h662E);
        push_exp(1'b0, 16'h62E3);
        push_exp(1'b0, 16'h2E33);
        push_exp(1'b1, 16'hE330);
        start_pulse(5);
        check("start_busy", 32'(busy), 32'd1);
        wait_tick_total(base + 5, 60);
        check("hello_window", 32'(window), 32'hE330);
        for (int i = 1; i < tick_cyc_q.size(); i++) begin
            check("scroll_gap", 32'(tick_cyc_q[i] - tick_cyc_q[i-1]), 32'd8);
        end

        // Stop freezes the window while the mux keeps running.
        stop_pulse();
        check("stop_busy", 32'(busy), 32'd0);
        base = tick_count;
        bad  = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (window !== 16'hE330) bad++;
            if (i < 16) begin
                check("stop_anode", 32'(anode), 32'(anode_exp[(rst_cyc / 4) % 4]));
                check("stop_digit_code", 32'(digit_code),
                      32'(exp_nibble(16'hE330, (rst_cyc / 4) % 4)));
            end
        end
        check("stop_window_changes", 32'(bad), 32'd0);
        check("stop_no_tick", 32'(tick_count), 32'(base));

        // Out-of-range lengths are ignored.
        start_pulse(0);
        steps(20);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_window", 32'(window), 32'hE330);
        start_pulse(33);
        steps(20);
        check("len33_busy", 32'(busy), 32'd0);
        check("len33_no_tick", 32'(tick_count), 32'(base));

        // Full-length message is accepted; start+stop together means stop.
        start_pulse(MAX_LEN);
        check("len32_busy", 32'(busy), 32'd1);
        check("len32_window", 32'(window), 32'h6666);
        msg_len = LEN_W'(5);
        start   = 1'b1;
        stop    = 1'b1;
        step();
        start   = 1'b0;
        stop    = 1'b0;
        check("start_stop_scroll_busy", 32'(busy), 32'd0);
        steps(20);
        check("start_stop_window", 32'(window), 32'h6666);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_idle_busy", 32'(busy), 32'd0);
        check("start_stop_no_tick", 32'(tick_count), 32'(base));

        // Write to buf[ptr] on the shift edge: old code shifts, new one next pass.
        base = tick_count;
        tick_cyc_q.delete();
        push_exp(1'b0, 16'h6662);
        push_exp(1'b0, 16'h662E);
        push_exp(1'b0, 16'h62E3);
        push_exp(1'b0, 16'h2E33);
        push_exp(1'b1, 16'hE330);
        push_exp(1'b0, 16'h3302);
        push_exp(1'b0, 16'h302F);
        start_pulse(5);
        wait_tick_total(base + 1, 20);
        steps(7);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(1);
        wr_data = CH_F;
        step();
        wr_en   = 1'b0;
        wait_tick_total(base + 7, 120);
        if (tick_cyc_q.size() >= 6) begin
            check("wrap_gap", 32'(tick_cyc_q[5] - tick_cyc_q[4]), 32'(WRAP_GAP));
        end
        stop_pulse();
        write_char(1, CH_E);

        // Reset mid-scroll dominates a simultaneous start.
        base = tick_count;
        push_exp(1'b0, 16'h6662);
        push_exp(1'b0, 16'h662E);
        start_pulse(5);
        wait_tick_total(base + 2, 40);
        reset_n = 1'b0;
        start   = 1'b1;
        msg_len = LEN_W'(5);
        step();
        check("rst_window", 32'(window), 32'h6666);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_anode", 32'(anode), 32'b1110);
        check("rst_digit_sel", 32'(digit_sel), 32'd0);
        check("rst_digit_code", 32'(digit_code), 32'h6);
        check("rst_scroll_tick", 32'(scroll_tick), 32'd0);
        reset_n = 1'b1;
        start   = 1'b0;
        steps(30);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_no_tick", 32'(tick_count), 32'(base + 2));

`ifdef BANNER_PAUSE_EN
        // Pause after each wrap, then resume from buf[0]; reset inside HOLD.
        base = tick_count;
        tick_cyc_q.delete();
        push_exp(1'b0, 16'h6662);
        push_exp(1'b0, 16'h662E);
        push_exp(1'b1, 16'h62E3);
        push_exp(1'b0, 16'h2E32);
        push_exp(1'b0, 16'hE32E);
        push_exp(1'b1, 16'h32E3);
        start_pulse(3);
        wait_tick_total(base + 6, 120);
        if (tick_cyc_q.size() >= 6) begin
            check("hold_gap", 32'(tick_cyc_q[3] - tick_cyc_q[2]), 32'd24);
            check("resume_gap", 32'(tick_cyc_q[4] - tick_cyc_q[3]), 32'd8);
        end
        steps(5);
        check("hold_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        step();
        check("hold_rst_window", 32'(window), 32'h6666);
        check("hold_rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        steps(30);
        check("hold_rst_no_tick", 32'(tick_count), 32'(base + 6));
`endif

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
